// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip8_pkg
// Brief    : Shared CHIP-8 constants, fetch FSM encoding and latency-tag type.
// Revision : 1.0
// ============================================================================
package chip8_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int OPCODE_W     = 16;

    localparam logic [11:0] FONT_BASE = 12'h000;
    localparam logic [11:0] PROG_BASE = 12'h200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_HI = 3'd1,
        ST_RD_LO = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic hi;
        logic lo;
    } lat_tag_t;

endpackage
`default_nettype wire

// File: rtl/chip8_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : chip8_lat_pipe
// Brief    : DEPTH-stage shift register of capture-hi/capture-lo tags that
//            marks the cycle in which each requested byte is on the read bus.
// Revision : 1.0
// ============================================================================
module chip8_lat_pipe
    import chip8_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_hi,
    input  logic push_lo,
    output logic cap_hi,
    output logic cap_lo
);

    lat_tag_t tag_q [DEPTH];
    lat_tag_t tag_d [DEPTH];

    always_comb begin
        tag_d[0].hi = push_hi;
        tag_d[0].lo = push_lo;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

    assign cap_hi = tag_q[DEPTH-1].hi;
    assign cap_lo = tag_q[DEPTH-1].lo;

endmodule
`default_nettype wire

// File: rtl/chip8_fetch.sv
`default_nettype none
// ============================================================================
// Module   : chip8_fetch
// Brief    : CHIP-8 instruction fetch: two byte reads (PC, PC+1) assembled
//            into a big-endian opcode behind a valid/ready handshake.
//            Optional misaligned-PC flag: CHIP8_FETCH_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================
module chip8_fetch
    import chip8_pkg::*;
#(
    parameter int ADDR_W      = CHIP8_ADDR_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_pc,
    output logic                fetch_ready,
    output logic                mem_read,
    output logic [ADDR_W-1:0]   mem_address,
    input  logic [7:0]          mem_data_out,
    output logic [OPCODE_W-1:0] opcode,
    output logic                opcode_valid,
    input  logic                opcode_ready,
    output logic                fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic                  mem_read_q, mem_read_d;
    logic [7:0]            hi_byte_q, hi_byte_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;

    logic accept;
    logic cap_hi;
    logic cap_lo;

    assign accept = (state_q == ST_IDLE) && fetch_req;

    // Tags enter the pipe in the cycle each address is on the bus, so they
    // exit exactly when the memory's registered data for that address lands.
    chip8_lat_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_hi (state_q == ST_RD_HI),
        .push_lo (state_q == ST_RD_LO),
        .cap_hi  (cap_hi),
        .cap_lo  (cap_lo)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_address_d = mem_address_q;
        mem_read_d    = 1'b0;
        hi_byte_d     = hi_byte_q;
        opcode_d      = opcode_q;

        if (cap_hi) begin
            hi_byte_d = mem_data_out;
        end

        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    pc_d          = fetch_pc;
                    mem_address_d = fetch_pc;
                    mem_read_d    = 1'b1;
                    state_d       = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                mem_address_d = pc_q + ADDR_W'(1);
                mem_read_d    = 1'b1;
                state_d       = ST_RD_LO;
            end
            ST_RD_LO: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The opcode register only changes here, so it never shows a half-built value.
                if (cap_lo) begin
                    opcode_d = {hi_byte_q, mem_data_out};
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (opcode_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            hi_byte_q     <= '0;
            opcode_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            hi_byte_q     <= hi_byte_d;
            opcode_q      <= opcode_d;
        end
    end

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (accept) begin
            fault_d = fetch_pc[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    assign fetch_ready  = (state_q == ST_IDLE);
    assign opcode_valid = (state_q == ST_DONE);
    assign mem_read     = mem_read_q;
    assign mem_address  = mem_address_q;
    assign opcode       = opcode_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_fetch
// Brief    : Directed self-checking bench for chip8_fetch (latency 1 and 2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_chip8_fetch;

    localparam int AW = 12;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          fetch_req, fetch_ready, mem_read, opcode_valid, opcode_ready, fetch_fault;
    logic [AW-1:0] fetch_pc, mem_address;
    logic [7:0]    mem_data_out;
    logic [15:0]   opcode;

    logic          fetch_req2, fetch_ready2, mem_read2, opcode_valid2, opcode_ready2, fetch_fault2;
    logic [AW-1:0] fetch_pc2, mem_address2;
    logic [7:0]    mem_data_out2;
    logic [15:0]   opcode2;

    logic [7:0] mem [4096];
    logic [7:0] rd1_q, rd2a_q, rd2b_q;

    always @(posedge clk) begin
        rd1_q  <= mem[mem_address];
        rd2a_q <= mem[mem_address2];
        rd2b_q <= rd2a_q;
    end
    assign mem_data_out  = rd1_q;
    assign mem_data_out2 = rd2b_q;

    chip8_fetch #(.ADDR_W(AW), .MEM_LATENCY(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .fetch_fault  (fetch_fault)
    );

    chip8_fetch #(.ADDR_W(AW), .MEM_LATENCY(2)) u_dut_l2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req2),
        .fetch_pc     (fetch_pc2),
        .fetch_ready  (fetch_ready2),
        .mem_read     (mem_read2),
        .mem_address  (mem_address2),
        .mem_data_out (mem_data_out2),
        .opcode       (opcode2),
        .opcode_valid (opcode_valid2),
        .opcode_ready (opcode_ready2),
        .fetch_fault  (fetch_fault2)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
        mem[12'h202] = 8'hA1; mem[12'h203] = 8'h23;
        mem[12'h204] = 8'h6A; mem[12'h205] = 8'h07;
        mem[12'h206] = 8'hD0; mem[12'h207] = 8'h15;
        mem[12'hFFF] = 8'h12; mem[12'h000] = 8'hF0;
        mem[12'h300] = 8'hA2; mem[12'h301] = 8'h2A;

        rst_n = 1'b0;
        fetch_req = 1'b0;  fetch_pc = '0;  opcode_ready = 1'b0;
        fetch_req2 = 1'b0; fetch_pc2 = '0; opcode_ready2 = 1'b0;
        step(); step();

        // Reset state
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_mem_read",    32'(mem_read), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'h000);
        chk("rst_opcode",      32'(opcode), 32'h0000);
        chk("rst_valid",       32'(opcode_valid), 32'd0);
        chk("rst_fault",       32'(fetch_fault), 32'd0);
        chk("rst_l2_ready",    32'(fetch_ready2), 32'd1);
        rst_n = 1'b1;

        // Basic fetch at 0x200 -> 00E0
        fetch_pc = 12'h200; fetch_req = 1'b1; opcode_ready = 1'b1;
        step();
        chk("t1_acc_read",  32'(mem_read), 32'd1);
        chk("t1_acc_addr",  32'(mem_address), 32'h200);
        chk("t1_acc_ready", 32'(fetch_ready), 32'd0);
        chk("t1_acc_valid", 32'(opcode_valid), 32'd0);
        fetch_req = 1'b0;
        step();
        chk("t1_lo_addr",  32'(mem_address), 32'h201);
        chk("t1_lo_read",  32'(mem_read), 32'd1);
        chk("t1_n1_valid", 32'(opcode_valid), 32'd0);
        step();
        chk("t1_n2_read",  32'(mem_read), 32'd0);
        chk("t1_n2_addr",  32'(mem_address), 32'h201);
        chk("t1_n2_valid", 32'(opcode_valid), 32'd0);
        step();
        chk("t1_n3_valid",  32'(opcode_valid), 32'd1);
        chk("t1_n3_opcode", 32'(opcode), 32'h00E0);
        step();
        chk("t1_n4_valid",  32'(opcode_valid), 32'd0);
        chk("t1_n4_ready",  32'(fetch_ready), 32'd1);
        chk("t1_n4_opcode", 32'(opcode), 32'h00E0);

        // Address wrap at 0xFFF -> 12F0
        fetch_pc = 12'hFFF; fetch_req = 1'b1;
        step();
        chk("t2_hi_addr", 32'(mem_address), 32'hFFF);
        fetch_req = 1'b0;
        step();
        chk("t2_lo_addr", 32'(mem_address), 32'h000);
        step(); step();
        chk("t2_valid",  32'(opcode_valid), 32'd1);
        chk("t2_opcode", 32'(opcode), 32'h12F0);
        step();
        chk("t2_drop", 32'(opcode_valid), 32'd0);

        // Back-pressure: opcode held, new requests ignored
        opcode_ready = 1'b0; fetch_pc = 12'h204; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step(); step(); step();
        chk("t3_valid",  32'(opcode_valid), 32'd1);
        chk("t3_opcode", 32'(opcode), 32'h6A07);
        fetch_req = 1'b1; fetch_pc = 12'h300;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_valid",  32'(opcode_valid), 32'd1);
            chk("t3_hold_opcode", 32'(opcode), 32'h6A07);
            chk("t3_hold_fready", 32'(fetch_ready), 32'd0);
            chk("t3_hold_read",   32'(mem_read), 32'd0);
            chk("t3_hold_addr",   32'(mem_address), 32'h205);
        end
        opcode_ready = 1'b1; fetch_pc = 12'h206;
        step();
        chk("t3_rel_valid",  32'(opcode_valid), 32'd0);
        chk("t3_rel_fready", 32'(fetch_ready), 32'd1);
        chk("t3_rel_read",   32'(mem_read), 32'd0);
        step();
        chk("t3_next_read", 32'(mem_read), 32'd1);
        chk("t3_next_addr", 32'(mem_address), 32'h206);
        fetch_req = 1'b0;
        step(); step(); step();
        chk("t3_next_valid",  32'(opcode_valid), 32'd1);
        chk("t3_next_opcode", 32'(opcode), 32'hD015);
        step();

        // Reset during RD_LO abandons the fetch
        fetch_pc = 12'h208; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        chk("t4_pre_addr", 32'(mem_address), 32'h209);
        rst_n = 1'b0;
        step();
        chk("t4_rst_fready", 32'(fetch_ready), 32'd1);
        chk("t4_rst_read",   32'(mem_read), 32'd0);
        chk("t4_rst_addr",   32'(mem_address), 32'h000);
        chk("t4_rst_opcode", 32'(opcode), 32'h0000);
        chk("t4_rst_valid",  32'(opcode_valid), 32'd0);
        chk("t4_rst_fault",  32'(fetch_fault), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_post_valid",  32'(opcode_valid), 32'd0);
            chk("t4_post_fready", 32'(fetch_ready), 32'd1);
        end

        // Odd PC: flagged only when alignment checking is built in
        fetch_pc = 12'h201; fetch_req = 1'b1;
        step();
        chk("t5_odd_fault", 32'(fetch_fault), 32'(ALIGN_EN));
        fetch_req = 1'b0;
        step(); step(); step();
        chk("t5_odd_valid",  32'(opcode_valid), 32'd1);
        chk("t5_odd_opcode", 32'(opcode), 32'hE0A1);
        chk("t5_odd_fault2", 32'(fetch_fault), 32'(ALIGN_EN));
        step();
        fetch_pc = 12'h202; fetch_req = 1'b1;
        step();
        chk("t5_even_fault", 32'(fetch_fault), 32'd0);
        fetch_req = 1'b0;
        step(); step(); step();
        chk("t5_even_valid",  32'(opcode_valid), 32'd1);
        chk("t5_even_opcode", 32'(opcode), 32'hA123);
        step();

        // MEM_LATENCY=2 instance: valid 4 clocks after acceptance
        fetch_pc2 = 12'h300; fetch_req2 = 1'b1; opcode_ready2 = 1'b1;
        step();
        chk("t6_hi_addr", 32'(mem_address2), 32'h300);
        chk("t6_hi_read", 32'(mem_read2), 32'd1);
        chk("t6_fault",   32'(fetch_fault2), 32'd0);
        fetch_req2 = 1'b0;
        step();
        chk("t6_lo_addr", 32'(mem_address2), 32'h301);
        step();
        chk("t6_n2_valid", 32'(opcode_valid2), 32'd0);
        step();
        chk("t6_n3_valid", 32'(opcode_valid2), 32'd0);
        step();
        chk("t6_n4_valid",  32'(opcode_valid2), 32'd1);
        chk("t6_n4_opcode", 32'(opcode2), 32'hA22A);
        step();
        chk("t6_n5_valid",  32'(opcode_valid2), 32'd0);
        chk("t6_n5_fready", 32'(fetch_ready2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
